direction_deque: RTL and testbench
==================================

# direction_deque

- Circular double-ended buffer of 2-bit move directions: 00 up, 01 right, 10 left, 11 down.
- It is the responder on the maze controller's path-storage interface. It accepts `push` with `dir` during search and serves `pop_back` (LIFO) during backtracking, returning the element on `stack_out`.
- It serves `pop_front` (FIFO) while the solved path is replayed.
- It reports empty and full status back to the controller.

## Interface

Parameters:
- DEPTH, 256, number of entries; any value ≥ 2; 256 covers a 16×16 maze.
- PW, $clog2(DEPTH), pointer width.
- CW, $clog2(DEPTH+1), occupancy counter width.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high; clears all state.
- our_reset  in  1  synchronous clear, same effect as Rst but taken at the clock edge.
- push  in  1  append `dir` at back.
- pop_back  in  1  remove the back element; it appears on `stack_out`.
- pop_front  in  1  remove the front element; it appears on `front_out`.
- dir  in  2  direction to push.
- stack_out  out  2  last element removed by `pop_back`; registered.
- front_out  out  2  last element removed by `pop_front`; registered.
- front_valid  out  1  one-cycle pulse: `front_out` was updated this cycle.
- is_deque_empty  out  1  count == 0.
- is_deque_full  out  1  count == DEPTH.
- count  out  CW  current occupancy.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

## Operation

State:
- mem[DEPTH] × 2 bits.
- head: index of the front element.
- tail: index of the next free slot at the back.
- count.
- Registered outputs stack_out, front_out, front_valid, overflow, underflow.

Reset (Rst, or our_reset at the edge):
- head = tail = count = 0.
- stack_out = front_out = 00; front_valid = 0; overflow = underflow = 0.
- mem contents are don't-care and are not cleared.

One operation per cycle. Priority is our_reset > pop_back > pop_front > push; lower-priority requests in the same cycle are ignored and have no effect.

- push, not full: mem[tail] ← dir; tail ← inc(tail); count+1.
- push, full: no change to mem, pointers or count; overflow ← 1.
- pop_back, not empty: t = dec(tail); stack_out ← mem[t]; tail ← t; count−1.
- pop_back, empty: stack_out holds; underflow ← 1.
- pop_front, not empty: front_out ← mem[head]; head ← inc(head); count−1; front_valid ← 1.
- pop_front, empty: front_out holds; front_valid ← 0; underflow ← 1.
- front_valid is 0 in every cycle that does not perform a successful pop_front.

Pointer wrap:
- inc(p) = (p == DEPTH−1) ? 0 : p+1.
- dec(p) = (p == 0) ? DEPTH−1 : p−1.
- No power-of-two assumption.

Single-element case: pop_back and pop_front both return that same element, and both leave the deque empty with head == tail.

## Timing

- Flags are combinational from registered count, so they reflect the result of an operation in the cycle after that operation's edge.
- Pop latency is 1 cycle. Request sampled at edge N; stack_out / front_out are valid after edge N and hold until the next successful pop of the same kind.
- This lets the controller assert pop_back in one state and decode stack_out in the following state.
- Push-to-pop: an element pushed at edge N is poppable at edge N+1.
- Back-to-back pushes or pops every cycle are sustained with no bubbles.
- Rst asserted mid-operation aborts immediately. The operation at the pending edge is discarded. Outputs are at reset values while Rst is high.
- overflow and underflow clear only on Rst or our_reset.

## Test plan

- Reset, then 4 pushes of 00, 01, 10, 11, then 4 pop_back → stack_out sequence 11, 10, 01, 00. count goes 4→0, then is_deque_empty = 1.
- Same 4 pushes, then pop_front held 5 cycles → front_out 00, 01, 10, 11, with front_valid high for exactly 4 cycles. 5th cycle: front_valid = 0, underflow = 1, front_out stays 11.
- DEPTH = 5: push 5 → is_deque_full = 1. 6th push (dir 10) → overflow = 1, count stays 5. pop_front ×3, push ×3 (tail wraps past index 4). pop_back ×5 → last-in-first-out order across the wrap.
- Push 01, then assert pop_back and pop_front in the same cycle → only pop_back acts. stack_out = 01, front_valid = 0, count = 0. Repeat with push and pop_front together on a deque holding 10 → front_out = 10, no push.
- Fill to 3 entries, assert Rst asynchronously between edges → immediately count = 0, empty = 1, stack_out = front_out = 00. A subsequent pop_back sets underflow.
- our_reset pulsed together with push → deque is cleared and the push is ignored (count = 0).

Source files
------------

// File: rtl/direction_deque.sv
// direction_deque: circular double-ended buffer of 2-bit move directions
// (00 up, 01 right, 10 left, 11 down) used as path storage by the maze controller.
// Back end works as a stack (push / pop_back) and the front end as a queue
// (pop_front). One operation per cycle, priority our_reset > pop_back > pop_front > push.
//
// Ports:
//   Clk            clock, all state changes on the rising edge
//   Rst            asynchronous active-high reset
//   our_reset      synchronous clear, same effect as Rst
//   push, dir      append dir at the back
//   pop_back       remove back element, registered onto stack_out
//   pop_front      remove front element, registered onto front_out
//   front_valid    one-cycle pulse after a successful pop_front
//   is_deque_empty count == 0
//   is_deque_full  count == DEPTH
//   count          current occupancy
//   overflow       sticky, push attempted while full
//   underflow      sticky, pop attempted while empty
module direction_deque #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          our_reset,
  input  logic          push,
  input  logic          pop_back,
  input  logic          pop_front,
  input  logic [1:0]    dir,
  output logic [1:0]    stack_out,
  output logic [1:0]    front_out,
  output logic          front_valid,
  output logic          is_deque_empty,
  output logic          is_deque_full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [1:0] mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    stack_q, stack_d;
  logic [1:0]    front_q, front_d;
  logic          fvalid_q, fvalid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          mem_we;
  logic [PW-1:0] tail_dec;

  // Wrap helpers; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  assign is_deque_empty = (count_q == '0);
  assign is_deque_full  = (count_q == CW'(DEPTH));
  assign tail_dec       = ptr_dec(tail_q);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    stack_d  = stack_q;
    front_d  = front_q;
    fvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    mem_we   = 1'b0;

    if (our_reset) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      stack_d = 2'b00;
      front_d = 2'b00;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (pop_back) begin
      if (!is_deque_empty) begin
        stack_d = mem[tail_dec];
        tail_d  = tail_dec;
        count_d = count_q - CW'(1);
      end else begin
        udf_d = 1'b1;
      end
    end else if (pop_front) begin
      if (!is_deque_empty) begin
        front_d  = mem[head_q];
        head_d   = ptr_inc(head_q);
        count_d  = count_q - CW'(1);
        fvalid_d = 1'b1;
      end else begin
        udf_d = 1'b1;
      end
    end else if (push) begin
      if (!is_deque_full) begin
        mem_we  = 1'b1;
        tail_d  = ptr_inc(tail_q);
        count_d = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      stack_q  <= 2'b00;
      front_q  <= 2'b00;
      fvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      stack_q  <= stack_d;
      front_q  <= front_d;
      fvalid_q <= fvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; its contents are irrelevant while count is zero.
  always_ff @(posedge Clk) begin
    if (mem_we && !Rst) begin
      mem[tail_q] <= dir;
    end
  end

  assign stack_out   = stack_q;
  assign front_out   = front_q;
  assign front_valid = fvalid_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_direction_deque.sv
// Directed table-driven bench for direction_deque, built with DEPTH = 5 so the
// pointer wrap and full/overflow cases are reachable with short sequences.
module tb_direction_deque;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Rst;
  logic          our_reset, push, pop_back, pop_front;
  logic [1:0]    dir;
  logic [1:0]    stack_out, front_out;
  logic          front_valid, is_deque_empty, is_deque_full, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int passed = 0;

  direction_deque #(.DEPTH(DEPTH)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .our_reset      (our_reset),
    .push           (push),
    .pop_back       (pop_back),
    .pop_front      (pop_front),
    .dir            (dir),
    .stack_out      (stack_out),
    .front_out      (front_out),
    .front_valid    (front_valid),
    .is_deque_empty (is_deque_empty),
    .is_deque_full  (is_deque_full),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       push, pb, pf, ors;
    logic [1:0] dir;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Packed expectation: {stack_out, front_out, front_valid, count, empty, full, ovf, udf}
  function automatic logic [11:0] pk(input logic [1:0] so, input logic [1:0] fo,
                                     input logic fv, input int cnt, input logic em,
                                     input logic fu, input logic ov, input logic un);
    logic [2:0] c;
    c = 3'(cnt);
    return {so, fo, fv, c, em, fu, ov, un};
  endfunction

  function automatic logic [11:0] actual();
    return {stack_out, front_out, front_valid, 3'(count), is_deque_empty, is_deque_full,
            overflow, underflow};
  endfunction

  task automatic add(input logic p, input logic pb, input logic pf, input logic ors,
                     input logic [1:0] d, input logic [11:0] e);
    vec_t v;
    v.push = p; v.pb = pb; v.pf = pf; v.ors = ors; v.dir = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = actual();
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got so/fo/fv/cnt/em/fu/ov/un=%b required %b", name, act, exp);
  endtask

  task automatic idle_inputs();
    push = 0; pop_back = 0; pop_front = 0; our_reset = 0; dir = 2'b00;
  endtask

  initial begin
    Rst = 1'b1;
    idle_inputs();

    // Test 1: pushes then LIFO pops
    add(1,0,0,0,2'b00, pk(2'b00,2'b00,0,1,0,0,0,0));
    add(1,0,0,0,2'b01, pk(2'b00,2'b00,0,2,0,0,0,0));
    add(1,0,0,0,2'b10, pk(2'b00,2'b00,0,3,0,0,0,0));
    add(1,0,0,0,2'b11, pk(2'b00,2'b00,0,4,0,0,0,0));
    add(0,1,0,0,2'b00, pk(2'b11,2'b00,0,3,0,0,0,0));
    add(0,1,0,0,2'b00, pk(2'b10,2'b00,0,2,0,0,0,0));
    add(0,1,0,0,2'b00, pk(2'b01,2'b00,0,1,0,0,0,0));
    add(0,1,0,0,2'b00, pk(2'b00,2'b00,0,0,1,0,0,0));
    // Test 2: pushes then FIFO pops, fifth pop underflows
    add(1,0,0,0,2'b00, pk(2'b00,2'b00,0,1,0,0,0,0));
    add(1,0,0,0,2'b01, pk(2'b00,2'b00,0,2,0,0,0,0));
    add(1,0,0,0,2'b10, pk(2'b00,2'b00,0,3,0,0,0,0));
    add(1,0,0,0,2'b11, pk(2'b00,2'b00,0,4,0,0,0,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b00,1,3,0,0,0,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b01,1,2,0,0,0,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b10,1,1,0,0,0,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b11,1,0,1,0,0,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b11,0,0,1,0,0,1));
    // our_reset together with push: cleared, push ignored
    add(1,0,0,1,2'b01, pk(2'b00,2'b00,0,0,1,0,0,0));
    // Test 3: fill, overflow, wrap, LIFO across wrap
    add(1,0,0,0,2'b00, pk(2'b00,2'b00,0,1,0,0,0,0));
    add(1,0,0,0,2'b01, pk(2'b00,2'b00,0,2,0,0,0,0));
    add(1,0,0,0,2'b10, pk(2'b00,2'b00,0,3,0,0,0,0));
    add(1,0,0,0,2'b11, pk(2'b00,2'b00,0,4,0,0,0,0));
    add(1,0,0,0,2'b00, pk(2'b00,2'b00,0,5,0,1,0,0));
    add(1,0,0,0,2'b10, pk(2'b00,2'b00,0,5,0,1,1,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b00,1,4,0,0,1,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b01,1,3,0,0,1,0));
    add(0,0,1,0,2'b00, pk(2'b00,2'b10,1,2,0,0,1,0));
    add(1,0,0,0,2'b11, pk(2'b00,2'b10,0,3,0,0,1,0));
    add(1,0,0,0,2'b01, pk(2'b00,2'b10,0,4,0,0,1,0));
    add(1,0,0,0,2'b10, pk(2'b00,2'b10,0,5,0,1,1,0));
    add(0,1,0,0,2'b00, pk(2'b10,2'b10,0,4,0,0,1,0));
    add(0,1,0,0,2'b00, pk(2'b01,2'b10,0,3,0,0,1,0));
    add(0,1,0,0,2'b00, pk(2'b11,2'b10,0,2,0,0,1,0));
    add(0,1,0,0,2'b00, pk(2'b00,2'b10,0,1,0,0,1,0));
    add(0,1,0,0,2'b00, pk(2'b11,2'b10,0,0,1,0,1,0));
    add(0,0,0,1,2'b00, pk(2'b00,2'b00,0,0,1,0,0,0));
    // Test 4: priority pop_back > pop_front > push
    add(1,0,0,0,2'b01, pk(2'b00,2'b00,0,1,0,0,0,0));
    add(0,1,1,0,2'b00, pk(2'b01,2'b00,0,0,1,0,0,0));
    add(1,0,0,0,2'b10, pk(2'b01,2'b00,0,1,0,0,0,0));
    add(1,0,1,0,2'b11, pk(2'b01,2'b10,1,0,1,0,0,0));
    // Fill to three ahead of the asynchronous reset sequence
    add(1,0,0,0,2'b01, pk(2'b01,2'b10,0,1,0,0,0,0));
    add(1,0,0,0,2'b10, pk(2'b01,2'b10,0,2,0,0,0,0));
    add(1,0,0,0,2'b11, pk(2'b01,2'b10,0,3,0,0,0,0));

    #12;
    check("reset_state", pk(2'b00,2'b00,0,0,1,0,0,0));
    @(posedge Clk);
    #1 Rst = 1'b0;

    foreach (vecs[i]) begin
      push = vecs[i].push; pop_back = vecs[i].pb; pop_front = vecs[i].pf;
      our_reset = vecs[i].ors; dir = vecs[i].dir;
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset between edges, with a push pending at the next edge
    push = 1'b1; dir = 2'b01;
    #1 Rst = 1'b1;
    #1 check("async_rst_immediate", pk(2'b00,2'b00,0,0,1,0,0,0));
    @(posedge Clk);
    #1 check("async_rst_push_discarded", pk(2'b00,2'b00,0,0,1,0,0,0));
    idle_inputs();
    Rst = 1'b0;
    pop_back = 1'b1;
    @(posedge Clk);
    #1 check("pop_back_after_rst_underflow", pk(2'b00,2'b00,0,0,1,0,0,1));
    idle_inputs();
    @(posedge Clk);
    #1 check("underflow_sticky", pk(2'b00,2'b00,0,0,1,0,0,1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
